reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, negedge-clocked register file. It adds:
- a configurable number of read and write ports, with write-to-read bypass;
- a per-register pending (scoreboard) bit for multi-cycle producers such as loads and the divider;
- a synchronised external trigger mapped onto a configurable architectural register.

It sits in decode: read ports feed the ID/EX operands, and write ports are driven from writeback.

## Interface
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 2, number of write ports (1..3); a higher index means higher priority
- TRIGGER_REG, 5, register index that reads the synchronised trigger
- OUT_REG, 10, register index mirrored on `a0`

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- trigger  in  1  asynchronous external input
- rd_addr  in  READ_PORTS*ADDRESS_WIDTH  read addresses; port i = slice i
- rd_data  out  READ_PORTS*DATA_WIDTH  read data, combinational
- rd_pending  out  READ_PORTS  pending bit for the addressed register, combinational
- wr_en  in  WRITE_PORTS  write enables
- wr_addr  in  WRITE_PORTS*ADDRESS_WIDTH  write addresses
- wr_data  in  WRITE_PORTS*DATA_WIDTH  write data
- iss_en  in  1  marks `iss_addr` pending (a multi-cycle op was issued)
- iss_addr  in  ADDRESS_WIDTH  destination of the issued op
- any_pending  out  1  OR of all pending bits
- a0  out  DATA_WIDTH  registered copy of register OUT_REG

## Operation
**Storage**
- Storage covers registers 1..depth-1. Register 0 always reads 0, is never pending, and writes to it are dropped.

**Write**
- Port w updates `wr_addr[w]` at the edge when `wr_en[w]`=1.
- If two or more ports target the same address in the same cycle, the highest-index port wins.
- Writes to TRIGGER_REG are dropped; it is read-only.

**Read**
- `rd_data[i]` is selected in this order:
  1. 0 if the address is 0.
  2. The synchronised trigger, zero-extended, if the address is TRIGGER_REG.
  3. The bypassed `wr_data` of the highest-index enabled write port whose address matches in the same cycle.
  4. Otherwise the stored value.

**Scoreboard**
- There is one pending bit per register.
- Clear: any enabled write to address r clears `pending[r]` at the edge.
- Set: `iss_en` sets `pending[iss_addr]` at the edge.
- If clear and set target the same r in the same cycle, set wins (the old producer completes, the new one is outstanding).
- `iss_addr` of 0 or TRIGGER_REG is ignored.
- `rd_pending[i]` = `pending[rd_addr[i]]` AND NOT (an enabled write to that address this cycle). This lets the consumer proceed in the same cycle the producer writes back.
- `any_pending` is computed from the stored bits only (no bypass).

**Trigger**
- `trigger` passes through a two-flop synchroniser.
- TRIGGER_REG reads the second flop.

**a0**
- `a0` is a flop loaded every cycle with the post-edge value of OUT_REG.
- If OUT_REG equals TRIGGER_REG, `a0` loads the synchronised trigger.

**Reset**
- While `rst_n`=0 at an edge, all registers, pending bits, synchroniser flops and `a0` clear to 0.
- Reset overrides any same-cycle write or issue.

## Timing
- Read latency: 0 cycles (combinational), including the bypass path.
- Write-to-read latency via storage: visible on the edge following the write.
- `a0`: updates on the same edge the write to OUT_REG commits; no extra cycle.
- `iss_en` at edge k: `rd_pending` and `any_pending` become 1 after edge k.
- Write at edge m: `rd_pending` drops to 0 combinationally during cycle m, and the stored bit clears at edge m.
- Trigger: a change stable before edge k is readable after edge k+1 (2-edge latency).
- Reset values of outputs:
  - `a0` = 0.
  - `any_pending` = 0.
  - `rd_pending` = 0.
  - `rd_data` = 0 for every address except live bypass; after reset all storage reads 0.
- Reset mid-operation clears all pending bits. Writebacks still in flight after reset are harmless (the write is accepted, and the clear is a no-op).

## Test plan
- Reset, then read all 32 addresses on both ports -> all 0. Confirm `a0`=0 and `any_pending`=0.
- Write port0 x7=0x1234_5678 and port1 x7=0xDEAD_BEEF in the same cycle, reading x7 that cycle.
  - Same cycle: `rd_data`=0xDEAD_BEEF via bypass.
  - Next cycle: `rd_data`=0xDEAD_BEEF from storage.
- Write x0=0xFFFF_FFFF and x5=0x1.
  - Reading x0 -> 0.
  - With `trigger`=0, reading x5 -> 0.
  - Drive `trigger`=1 -> x5 reads 1 exactly two edges later.
- Issue x9, wait 3 cycles, then write x9=0x42 on port1 while reading x9.
  - `rd_pending`=1 and `any_pending`=1 during the wait cycles.
  - In the write cycle: `rd_pending`=0 and `rd_data`=0x42.
  - After the edge: `any_pending`=0.
- Same-cycle `iss_en` x9 and write x9=0x10 -> after the edge, x9 reads 0x10 and `rd_pending`=1.
- Write x10=0xCAFE_F00D -> `a0`=0xCAFE_F00D after that edge. Then assert `rst_n`=0 with a concurrent write x10=0x1 -> `a0`=0 and x10 reads 0.

Source files
------------

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port integer register file with write-to-read bypass,
//            per-register pending scoreboard and a synchronised trigger input.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2,
    parameter int TRIGGER_REG   = 5,
    parameter int OUT_REG       = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                trigger,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [READ_PORTS-1:0]               rd_pending,
    input  logic [WRITE_PORTS-1:0]              wr_en,
    input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   wr_data,
    input  logic                                iss_en,
    input  logic [ADDRESS_WIDTH-1:0]            iss_addr,
    output logic                                any_pending,
    output logic [DATA_WIDTH-1:0]               a0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH-1:0] c_trig_addr = ADDRESS_WIDTH'(TRIGGER_REG);
    // Registers that can never hold a pending bit: x0 and the trigger register.
    localparam logic [DEPTH-1:0] c_ro_mask = DEPTH'(1) | (DEPTH'(1) << TRIGGER_REG);

    logic [ADDRESS_WIDTH-1:0] w_waddr [WRITE_PORTS];
    logic [DATA_WIDTH-1:0]    w_wdata [WRITE_PORTS];

    logic [DEPTH-1:0]         w_wr_hit;
    logic [DATA_WIDTH-1:0]    w_wr_val [DEPTH];
    logic [DATA_WIDTH-1:0]    w_store  [DEPTH];

    logic [DEPTH-1:0]         r_pending;
    logic [DEPTH-1:0]         w_pending_nxt;

    logic                     r_trig_meta;
    logic                     r_trig_sync;

    logic [DATA_WIDTH-1:0]    r_a0;
    logic [DATA_WIDTH-1:0]    w_a0_nxt;

    for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wslice
        assign w_waddr[w] = wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_wdata[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        // Priority chain across write ports: a later (higher-index) match overrides.
        for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_prio
            logic                  w_match;
            logic                  w_hit;
            logic [DATA_WIDTH-1:0] w_val;

            assign w_match = wr_en[w] && (w_waddr[w] == ADDRESS_WIDTH'(r));

            if (w == 0) begin : g_first
                assign w_hit = w_match;
                assign w_val = w_match ? w_wdata[w] : '0;
            end else begin : g_next
                assign w_hit = w_match | g_prio[w-1].w_hit;
                assign w_val = w_match ? w_wdata[w] : g_prio[w-1].w_val;
            end
        end

        assign w_wr_hit[r] = g_prio[WRITE_PORTS-1].w_hit;
        assign w_wr_val[r] = g_prio[WRITE_PORTS-1].w_val;

        if (r == 0 || r == TRIGGER_REG) begin : g_fixed
            assign w_store[r] = '0;
        end else begin : g_stored
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_wr_hit[r]) begin
                    r_q <= w_wr_val[r];
                end
            end

            assign w_store[r] = r_q;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_a;
        logic [DATA_WIDTH-1:0]    w_d;

        assign w_a = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        always_comb begin
            w_d = w_store[w_a];
            if (w_a == '0) begin
                w_d = '0;
            end else if (w_a == c_trig_addr) begin
                w_d = DATA_WIDTH'(r_trig_sync);
            end else if (w_wr_hit[w_a]) begin
                w_d = w_wr_val[w_a];
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_d;
        // A same-cycle writeback releases the consumer immediately.
        assign rd_pending[i] = r_pending[w_a] & ~w_wr_hit[w_a];
    end

    // Set is applied after clear so a new issue survives an old producer's writeback.
    always_comb begin
        w_pending_nxt = r_pending & ~w_wr_hit;
        if (iss_en) begin
            w_pending_nxt[iss_addr] = 1'b1;
        end
        w_pending_nxt = w_pending_nxt & ~c_ro_mask;
    end

    if (OUT_REG == 0) begin : g_a0_zero
        assign w_a0_nxt = '0;
    end else if (OUT_REG == TRIGGER_REG) begin : g_a0_trig
        assign w_a0_nxt = DATA_WIDTH'(r_trig_meta);
    end else begin : g_a0_reg
        assign w_a0_nxt = w_wr_hit[OUT_REG] ? w_wr_val[OUT_REG] : w_store[OUT_REG];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_trig_meta <= 1'b0;
            r_trig_sync <= 1'b0;
            r_a0        <= '0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_trig_meta <= trigger;
            r_trig_sync <= r_trig_meta;
            r_a0        <= w_a0_nxt;
        end
    end

    assign any_pending = |r_pending;
    assign a0          = r_a0;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// Testbench for reg_file_mp: directed vectors checked against literal values and
// against a cycle-level behavioural model of the register file.
module tb_reg_file_mp;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int RP   = 2;
    localparam int WP   = 2;
    localparam int TRIG = 5;
    localparam int OUTR = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trigger;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*DW-1:0]  rd_data;
    logic [RP-1:0]     rd_pending;
    logic [WP-1:0]     wr_en;
    logic [WP*AW-1:0]  wr_addr;
    logic [WP*DW-1:0]  wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              any_pending;
    logic [DW-1:0]     a0;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_s1;
    bit          m_s2;
    logic [31:0] m_a0;

    reg_file_mp #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .READ_PORTS   (RP),
        .WRITE_PORTS  (WP),
        .TRIGGER_REG  (TRIG),
        .OUT_REG      (OUTR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .any_pending(any_pending),
        .a0         (a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        if (a == 5'(TRIG)) return {31'd0, m_s2};
        v = m_regs[a];
        for (int w = 0; w < WP; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*DW +: DW];
        return v;
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        if (!m_pend[a]) return 1'b0;
        for (int w = 0; w < WP; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_any();
        for (int r = 0; r < 32; r++)
            if (m_pend[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic [4:0] a;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_pend[r] = 1'b0;
            end
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_a0 = 32'd0;
        end else begin
            // ascending port order so the highest-index port lands last
            for (int w = 0; w < WP; w++) begin
                if (wr_en[w]) begin
                    a = wr_addr[w*AW +: AW];
                    m_pend[a] = 1'b0;
                    if (a != 5'd0 && a != 5'(TRIG)) m_regs[a] = wr_data[w*DW +: DW];
                end
            end
            if (iss_en && iss_addr != 5'd0 && iss_addr != 5'(TRIG)) m_pend[iss_addr] = 1'b1;
            m_s2 = m_s1;
            m_s1 = trigger;
            m_a0 = m_regs[OUTR];
        end
    endtask

    // Model update on every rising edge, full output comparison on every falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            for (int i = 0; i < RP; i++) begin
                chk($sformatf("model rd_data[%0d]", i), rd_data[i*DW +: DW],
                    exp_rd(rd_addr[i*AW +: AW]));
                chk($sformatf("model rd_pending[%0d]", i), 32'(rd_pending[i]),
                    32'(exp_pend(rd_addr[i*AW +: AW])));
            end
            chk("model any_pending", 32'(any_pending), 32'(exp_any()));
            chk("model a0", a0, m_a0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        trigger  = 1'b0;
        iss_en   = 1'b0;
        iss_addr = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state: every address reads zero on both ports.
        @(negedge clk);
        chk("reset a0", a0, 32'd0);
        chk("reset any_pending", 32'(any_pending), 32'd0);
        chk("reset rd_pending", 32'(rd_pending), 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {a[4:0], a[4:0]};
            #1;
            chk($sformatf("reset rd0 x%0d", a), rd_data[31:0], 32'd0);
            chk($sformatf("reset rd1 x%0d", a), rd_data[63:32], 32'd0);
        end

        // Two ports write x7 together: port1 wins, bypass then storage.
        step();
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'hDEAD_BEEF, 32'h1234_5678};
        rd_addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("bypass x7", rd_data[31:0], 32'hDEAD_BEEF);
        step();
        wr_en = 2'b00;
        @(negedge clk);
        chk("stored x7", rd_data[63:32], 32'hDEAD_BEEF);

        // x0 and the trigger register ignore writes.
        step();
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd0};
        wr_data = {32'h0000_0001, 32'hFFFF_FFFF};
        rd_addr = {5'd5, 5'd0};
        @(negedge clk);
        chk("x0 reads 0", rd_data[31:0], 32'd0);
        chk("x5 trig low", rd_data[63:32], 32'd0);
        step();
        wr_en   = 2'b00;
        trigger = 1'b1;
        @(negedge clk);
        chk("trig before edge k", rd_data[63:32], 32'd0);
        step();
        @(negedge clk);
        chk("trig after edge k", rd_data[63:32], 32'd0);
        step();
        @(negedge clk);
        chk("trig after edge k+1", rd_data[63:32], 32'd1);

        // Scoreboard: issue x9, wait, then complete on port1.
        step();
        trigger  = 1'b0;
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        rd_addr  = {5'd9, 5'd9};
        @(negedge clk);
        chk("pend before issue edge", 32'(rd_pending[0]), 32'd0);
        step();
        iss_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("pend wait rd_pending", 32'(rd_pending[0]), 32'd1);
            chk("pend wait any_pending", 32'(any_pending), 32'd1);
            step();
        end
        wr_en   = 2'b10;
        wr_addr = {5'd9, 5'd0};
        wr_data = {32'h0000_0042, 32'd0};
        @(negedge clk);
        chk("writeback rd_pending", 32'(rd_pending[0]), 32'd0);
        chk("writeback bypass", rd_data[31:0], 32'h42);
        chk("writeback any stored", 32'(any_pending), 32'd1);
        step();
        wr_en = 2'b00;
        @(negedge clk);
        chk("after writeback any", 32'(any_pending), 32'd0);

        // Same-cycle issue and writeback: data lands, pending stays set.
        step();
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd9};
        wr_data  = {32'd0, 32'h0000_0010};
        step();
        iss_en = 1'b0;
        wr_en  = 2'b00;
        @(negedge clk);
        chk("set wins data", rd_data[31:0], 32'h10);
        chk("set wins pending", 32'(rd_pending[0]), 32'd1);

        // a0 mirror and reset overriding a concurrent write.
        step();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd10};
        wr_data = {32'd0, 32'hCAFE_F00D};
        step();
        wr_en = 2'b00;
        @(negedge clk);
        chk("a0 mirror", a0, 32'hCAFE_F00D);
        step();
        rst_n   = 1'b0;
        wr_en   = 2'b01;
        wr_data = {32'd0, 32'h0000_0001};
        step();
        rst_n   = 1'b1;
        wr_en   = 2'b00;
        rd_addr = {5'd10, 5'd10};
        @(negedge clk);
        chk("reset a0 cleared", a0, 32'd0);
        chk("reset x10 cleared", rd_data[31:0], 32'd0);
        chk("reset pending cleared", 32'(any_pending), 32'd0);

        // Trigger register write dropped: reads the (low) synchronised trigger.
        step();
        wr_en   = 2'b10;
        wr_addr = {5'd5, 5'd0};
        wr_data = {32'h0000_0ABC, 32'd0};
        step();
        wr_en   = 2'b00;
        rd_addr = {5'd0, 5'd5};
        @(negedge clk);
        chk("trig reg read-only", rd_data[31:0], 32'd0);

        // Mixed traffic on a narrow address range to force collisions.
        for (int n = 0; n < 80; n++) begin
            step();
            rst_n    = ($urandom_range(0, 39) != 0);
            wr_en    = WP'($urandom);
            wr_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            wr_data  = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = 5'($urandom_range(0, 11));
            trigger  = 1'($urandom);
            rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
        end

        step();
        rst_n  = 1'b1;
        wr_en  = 2'b00;
        iss_en = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
